// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Central sequencing FSM of the tiny calculator. Takes 5-bit
//                key tokens over a valid/ready handshake, builds decimal
//                operands, issues operations to the arithmetic unit over a
//                request/done handshake and drives the display value/error.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_key/_valid      - key token in, o_key_ready accepts it
//                o_alu_a/b/op      - operation request contents
//                o_alu_valid       - request valid, i_alu_ready accepts it
//                i_alu_done        - result pulse with i_alu_result/i_alu_err
//                o_disp_value/err  - registered display value / error flag
//                o_disp_update     - one-cycle pulse when the display changes
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       i_key,
   input  logic             i_key_valid,
   output logic             o_key_ready,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [1:0]       o_alu_op,
   output logic             o_alu_valid,
   input  logic             i_alu_ready,
   input  logic             i_alu_done,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_err,
   output logic [WIDTH-1:0] o_disp_value,
   output logic             o_disp_err,
   output logic             o_disp_update
);

   // Accumulation is done 4 bits wider so a*10+d can never wrap silently.
   localparam int                c_EXT = WIDTH + 4;
   localparam logic [c_EXT-1:0] c_TEN = c_EXT'(10);

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_OP_SEL  = 3'd1,
      ST_ENTER_B = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RESULT  = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_a, w_a_n;
   logic [WIDTH-1:0] r_b, w_b_n;
   logic [1:0]       r_op, w_op_n;
   logic [1:0]       r_pend_op, w_pend_op_n;
   logic             r_pend_flag, w_pend_flag_n;
   logic [WIDTH-1:0] r_disp_value;
   logic             r_disp_err;
   logic             r_disp_update;

   logic             w_ready;
   logic             w_accept;
   logic             w_is_digit;
   logic             w_is_ac;
   logic             w_is_op;
   logic             w_is_eq;
   logic [1:0]       w_key_op;
   logic [WIDTH-1:0] w_digit;
   logic [WIDTH-1:0] w_acc_src;
   logic [c_EXT-1:0] w_acc_wide;
   logic             w_acc_ovf;
   logic [WIDTH-1:0] w_disp_value_n;
   logic             w_disp_err_n;

   // ---------------------------------------------------------------- decode
   assign w_ready    = (r_state != ST_ISSUE) && (r_state != ST_WAIT);
   assign w_accept   = i_key_valid && w_ready;
   assign w_is_digit = (i_key <= 5'h09);
   assign w_is_ac    = (i_key == 5'h10);
   assign w_is_op    = (i_key >= 5'h11) && (i_key <= 5'h14);
   assign w_is_eq    = (i_key == 5'h15);
   // 0x11..0x14 -> 00..11: the low two bits minus one (0x14 wraps 00 -> 11).
   assign w_key_op   = i_key[1:0] - 2'd1;
   assign w_digit    = {{(WIDTH-4){1'b0}}, i_key[3:0]};

   // Only one operand is ever being typed, so a single accumulator suffices.
   assign w_acc_src  = (r_state == ST_ENTER_B) ? r_b : r_a;
   assign w_acc_wide = ({4'd0, w_acc_src} * c_TEN) + {{WIDTH{1'b0}}, i_key[3:0]};
   assign w_acc_ovf  = |w_acc_wide[c_EXT-1:WIDTH];

   // ------------------------------------------------------ next-state logic
   always_comb begin
      w_state_n     = r_state;
      w_a_n         = r_a;
      w_b_n         = r_b;
      w_op_n        = r_op;
      w_pend_op_n   = r_pend_op;
      w_pend_flag_n = r_pend_flag;

      if (w_accept) begin
         if (w_is_ac) begin
            w_a_n         = '0;
            w_b_n         = '0;
            w_pend_flag_n = 1'b0;
            w_state_n     = ST_ENTER_A;
         end else begin
            case (r_state)
               ST_ENTER_A: begin
                  if (w_is_digit && !w_acc_ovf) begin
                     w_a_n = w_acc_wide[WIDTH-1:0];
                  end else if (w_is_op) begin
                     w_op_n    = w_key_op;
                     w_state_n = ST_OP_SEL;
                  end
               end
               ST_OP_SEL: begin
                  if (w_is_digit) begin
                     w_b_n     = w_digit;
                     w_state_n = ST_ENTER_B;
                  end else if (w_is_op) begin
                     w_op_n = w_key_op;
                  end
               end
               ST_ENTER_B: begin
                  if (w_is_digit && !w_acc_ovf) begin
                     w_b_n = w_acc_wide[WIDTH-1:0];
                  end else if (w_is_eq) begin
                     w_pend_flag_n = 1'b0;
                     w_state_n     = ST_ISSUE;
                  end else if (w_is_op) begin
                     w_pend_op_n   = w_key_op;
                     w_pend_flag_n = 1'b1;
                     w_state_n     = ST_ISSUE;
                  end
               end
               ST_RESULT: begin
                  if (w_is_digit) begin
                     w_a_n     = w_digit;
                     w_state_n = ST_ENTER_A;
                  end else if (w_is_op) begin
                     w_op_n    = w_key_op;
                     w_state_n = ST_OP_SEL;
                  end
               end
               default: ;  // ERROR swallows everything except AC
            endcase
         end
      end else begin
         case (r_state)
            ST_ISSUE: begin
               if (i_alu_ready) begin
                  w_state_n = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_alu_done) begin
                  if (i_alu_err) begin
                     w_state_n = ST_ERROR;
                  end else begin
                     w_a_n = i_alu_result;
                     w_b_n = '0;
                     if (r_pend_flag) begin
                        w_op_n        = r_pend_op;
                        w_pend_flag_n = 1'b0;
                        w_state_n     = ST_OP_SEL;
                     end else begin
                        w_state_n = ST_RESULT;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      // Display follows the next state so a token's effect and the update
      // pulse appear in the cycle right after it is accepted.
      w_disp_err_n   = (w_state_n == ST_ERROR);
      w_disp_value_n = w_disp_err_n                ? '0    :
                       (w_state_n == ST_ENTER_B)   ? w_b_n : w_a_n;
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_ENTER_A;
         r_a           <= '0;
         r_b           <= '0;
         r_op          <= '0;
         r_pend_op     <= '0;
         r_pend_flag   <= 1'b0;
         r_disp_value  <= '0;
         r_disp_err    <= 1'b0;
         r_disp_update <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_a           <= w_a_n;
         r_b           <= w_b_n;
         r_op          <= w_op_n;
         r_pend_op     <= w_pend_op_n;
         r_pend_flag   <= w_pend_flag_n;
         r_disp_value  <= w_disp_value_n;
         r_disp_err    <= w_disp_err_n;
         r_disp_update <= (w_disp_value_n != r_disp_value) ||
                          (w_disp_err_n != r_disp_err);
      end
   end

   // --------------------------------------------------------------- outputs
   assign o_key_ready   = w_ready;
   assign o_alu_valid   = (r_state == ST_ISSUE);
   // Request fields read as zero whenever no request is outstanding.
   assign o_alu_a       = o_alu_valid ? r_a  : '0;
   assign o_alu_b       = o_alu_valid ? r_b  : '0;
   assign o_alu_op      = o_alu_valid ? r_op : 2'b00;
   assign o_disp_value  = r_disp_value;
   assign o_disp_err    = r_disp_err;
   assign o_disp_update = r_disp_update;

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Central sequencing FSM for the tiny calculator. It consumes 5-bit key tokens from the keypad/button reader over a valid/ready handshake and builds decimal operands. It issues operations to the arithmetic unit over a request/done handshake and drives the display value and error flag. It sits between the button reader and the ALU/display path.

## Interface
- `WIDTH`, default 16: operand, result and display width in bits; unsigned.
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `i_key`, in, 5: key token.
  - 0x00–0x09: digits.
  - 0x10: AC. 0x11: ADD. 0x12: SUB. 0x13: MUL. 0x14: DIV. 0x15: EQ.
  - All other codes are consumed and ignored.
- `i_key_valid`, in, 1: `i_key` is valid.
- `o_key_ready`, out, 1: the sequencer accepts a token this cycle.
- `o_alu_a`, out, WIDTH: operand A.
- `o_alu_b`, out, WIDTH: operand B.
- `o_alu_op`, out, 2: 00 add, 01 sub, 10 mul, 11 div.
- `o_alu_valid`, out, 1: operation request.
- `i_alu_ready`, in, 1: the ALU accepts the request.
- `i_alu_done`, in, 1: single-cycle pulse; result present.
- `i_alu_result`, in, WIDTH: result, sampled with `i_alu_done`.
- `i_alu_err`, in, 1: divide-by-zero, underflow or overflow, sampled with `i_alu_done`.
- `o_disp_value`, out, WIDTH: value to display.
- `o_disp_err`, out, 1: display shows the error indication.
- `o_disp_update`, out, 1: one-cycle pulse when `o_disp_value` or `o_disp_err` changes.

## Operation
- **Token transfer:** a token transfers on a cycle where `i_key_valid && o_key_ready`. Only then is it acted on.
- **Registers:** `a`, `b`, `op`, `pend_op`, `pend_flag`, state.
- **States:** ENTER_A, OP_SEL, ENTER_B, ISSUE, WAIT, RESULT, ERROR.
- **`o_key_ready`:** 1 in ENTER_A, OP_SEL, ENTER_B, RESULT and ERROR. 0 in ISSUE and WAIT.
- **AC:** in any ready state, AC sets `a=b=0`, clears `pend_flag`, clears the error and goes to ENTER_A.
- **ENTER_A**
  - Digit d: `a = a*10 + d`. If the exact result exceeds 2^WIDTH−1, the digit is dropped (still consumed).
  - Op: `op` = code; go to OP_SEL.
  - EQ: ignored.
- **OP_SEL**
  - Digit d: `b = d`; go to ENTER_B.
  - Op: replaces `op`.
  - EQ: ignored.
- **ENTER_B**
  - Digit: accumulates into `b` with the same overflow rule as ENTER_A.
  - EQ: go to ISSUE with `pend_flag=0`.
  - Op: `pend_op` = code, `pend_flag=1`; go to ISSUE (chaining).
- **ISSUE**
  - `o_alu_valid=1`, with `o_alu_a=a`, `o_alu_b=b`, `o_alu_op=op`.
  - These outputs are held stable until `i_alu_ready`, then go to WAIT.
- **WAIT:** on `i_alu_done`:
  - If `err`: go to ERROR.
  - Else `a = result`, `b = 0`.
  - If `pend_flag`: `op = pend_op`, clear `pend_flag`, go to OP_SEL.
  - Otherwise go to RESULT.
- **RESULT**
  - Digit d: `a = d`; go to ENTER_A.
  - Op: `op` = code; go to OP_SEL.
  - EQ: ignored.
- **ERROR:** `o_disp_err=1`, `o_disp_value=0`. All tokens except AC are consumed and ignored.
- **Display source:** `b` in ENTER_B; `a` in every other non-error state.
- **`o_disp_update`:** pulses whenever the registered display value or error flag changes.
- **Stray done:** `i_alu_done` outside WAIT is ignored.

## Timing
- **Reset values:** after the edge with `rst=1`:
  - State ENTER_A, all registers 0.
  - `o_key_ready=1`, `o_alu_valid=0`, `o_alu_a/b/op=0`.
  - `o_disp_value=0`, `o_disp_err=0`, `o_disp_update=0`.
- **Token latency:** a token accepted at edge N has its effect visible (registers, display) after edge N, i.e. one cycle. `o_disp_update` is high during that same cycle.
- **Issue:** EQ or a chaining op accepted at edge N gives `o_alu_valid=1` from cycle N+1. The request completes on the first edge with `i_alu_ready=1`; `o_alu_valid` is 0 in the following cycle.
- **Completion:** `i_alu_done` at edge M updates the display and state after M. `o_key_ready` returns to 1 in cycle M+1.
- **Backpressure:** while not ready, the token source must hold its token; no token is lost or duplicated.
- **Reset priority:** reset overrides every state, including ISSUE and WAIT. An `i_alu_done` arriving after reset is ignored.
- **Same-cycle key and done:** a key and `i_alu_done` in the same cycle cannot conflict, because `o_key_ready=0` in WAIT.

## Test plan
- **Reset:** assert `rst` 2 cycles.
  - → All outputs at their reset values; `o_key_ready=1`.
- **Basic add:** keys 1,2,ADD,3,4,EQ; ALU ready immediately; done with result 46.
  - → ALU sees a=12, b=34, op=00.
  - → `o_disp_value` sequence 1, 12, 12, 3, 34, 46; `o_disp_err=0`.
- **Chaining:** keys 5,MUL,6,SUB.
  - → Issue mul(5,6); result 30 → OP_SEL, op=01, display 30.
  - → Then keys 4,EQ → issue sub(30,4).
- **Digit overflow (WIDTH=16):** keys 6,5,5,3,5 then 0.
  - → Display 65535; the 0 is consumed with the display unchanged.
- **Divide-by-zero:** keys 7,DIV,0,EQ; ALU returns err=1.
  - → `o_disp_err=1`, `o_disp_value=0`; digit 3 is ignored.
  - → AC → err 0, display 0, state ENTER_A.
- **Backpressure and mid-operation reset:**
  - Hold `i_alu_ready=0` 3 cycles → `o_alu_valid`, a, b, op stable; `o_key_ready=0`; a pending key is not consumed.
  - Assert `rst` in WAIT, then pulse `i_alu_done` → all outputs stay at their reset values.
